// File: rtl/alu_operand_serializer.sv
// alu_operand_serializer
//   Parallel-to-serial front end for the serial ALU. It accepts one operand,
//   either a single register or a register pair, through a valid/ready
//   handshake. It shifts the operand into the ALU NSHIFT bits per active
//   cycle, LSB first. In the same cycles it gathers the ALU serial output
//   into a parallel result, which it offers downstream through a second
//   valid/ready handshake.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   load_valid/ready operand handshake; load_data holds the operand
//                    (only the low REG_BITS bits are used when load_pair=0)
//   load_pair        1 = register-pair operand, 0 = single register
//   operand_valid    operand loaded and not yet fully consumed
//   alu_active       ALU consumes/produces one NSHIFT chunk this cycle
//   alu_op_done      ALU marks its last cycle
//   alu_data_out     ALU serial result chunk
//   data_in          current operand chunk, to ALU data_in2
//   result_valid/ready  result handshake; result_data is right-aligned
//   err              sticky length-mismatch flag, cleared on the next load
module alu_operand_serializer #(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [2*REG_BITS-1:0] load_data,
  input  logic                  load_pair,
  output logic                  operand_valid,
  input  logic                  alu_active,
  input  logic                  alu_op_done,
  input  logic [NSHIFT-1:0]     alu_data_out,
  output logic [NSHIFT-1:0]     data_in,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [2*REG_BITS-1:0] result_data,
  output logic                  err
);

  localparam int W             = 2 * REG_BITS;
  localparam int PAIR_CHUNKS   = W / NSHIFT;
  localparam int SINGLE_CHUNKS = REG_BITS / NSHIFT;
  localparam int CW            = $clog2(PAIR_CHUNKS) + 1;
  localparam logic [CW-1:0] PAIR_LAST   = CW'(PAIR_CHUNKS - 1);
  localparam logic [CW-1:0] SINGLE_LAST = CW'(SINGLE_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    opnd_sr_reg;
  logic [W-1:0]    res_sr_reg;
  logic [W-1:0]    result_data_reg;
  logic [CW-1:0]   count_reg;
  logic            pair_reg;
  logic            err_reg;

  logic            last;
  logic            accept;
  logic            step;
  logic            complete;
  logic [W-1:0]    res_shifted;
  logic [W-1:0]    opnd_load;

  assign last        = pair_reg ? (count_reg == PAIR_LAST) : (count_reg == SINGLE_LAST);
  assign accept      = (state_reg == IDLE) && load_valid;
  assign step        = (state_reg == SHIFT) && alu_active;
  // Completion is forced at the natural last chunk, so count never wraps.
  assign complete    = step && (last || alu_op_done);
  assign res_shifted = {alu_data_out, res_sr_reg[W-1:NSHIFT]};
  // Upper byte of a single operand is dropped so it can never leak out.
  assign opnd_load   = load_pair ? load_data : {{REG_BITS{1'b0}}, load_data[REG_BITS-1:0]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_next    = state_reg;
    load_ready    = 1'b0;
    operand_valid = 1'b0;
    result_valid  = 1'b0;
    data_in       = '0;
    case (state_reg)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        operand_valid = 1'b1;
        data_in       = opnd_sr_reg[NSHIFT-1:0];
        if (complete) begin
          state_next = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_sr_reg     <= '0;
      res_sr_reg      <= '0;
      result_data_reg <= '0;
      count_reg       <= '0;
      pair_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      if (accept) begin
        opnd_sr_reg <= opnd_load;
        pair_reg    <= load_pair;
        count_reg   <= '0;
        res_sr_reg  <= '0;
        err_reg     <= 1'b0;
      end else if (step) begin
        opnd_sr_reg <= opnd_sr_reg >> NSHIFT;
        res_sr_reg  <= res_shifted;
        count_reg   <= count_reg + CW'(1);
        if (complete) begin
          // The final chunk is part of the result; a single result sits in
          // the upper half of the shifter and is moved down here.
          result_data_reg <= pair_reg ? res_shifted : (res_shifted >> REG_BITS);
          if (alu_op_done != last) begin
            err_reg <= 1'b1;
          end
        end
      end else if ((state_reg == DONE) && result_ready) begin
        result_data_reg <= '0;
      end
    end
  end

  assign result_data = result_data_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_alu_operand_serializer.sv
module tb_alu_operand_serializer;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        load_pair;
  logic        operand_valid;
  logic        alu_active;
  logic        alu_op_done;
  logic [1:0]  alu_data_out;
  logic [1:0]  data_in;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] result_data;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];

  alu_operand_serializer #(.REG_BITS(8), .NSHIFT(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_data     (load_data),
    .load_pair     (load_pair),
    .operand_valid (operand_valid),
    .alu_active    (alu_active),
    .alu_op_done   (alu_op_done),
    .alu_data_out  (alu_data_out),
    .data_in       (data_in),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_data   (result_data),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load an operand, then drive done_at/feed through the SHIFT phase.
  // Leaves the DUT in DONE (checked) with the expected result queued.
  task automatic run_shift(input logic [15:0] d, input bit p, input int done_at,
                           input bit toggle, input logic [15:0] feed);
    int nat;
    int n;
    int act_cnt;
    int cyc;
    bit act;
    logic [15:0] res;
    exp_t e;
    nat     = p ? 8 : 4;
    n       = (done_at < nat) ? done_at : nat;
    act_cnt = 0;
    cyc     = 0;
    res     = 16'h0000;
    for (int i = 0; i < n; i++) begin
      res = {feed[2*i +: 2], res[15:2]};
    end
    e.res = p ? res : (res >> 8);
    e.err = (done_at != nat);
    sb.push_back(e);

    chk("load_ready_idle", 16'(load_ready), 16'd1);
    load_valid = 1'b1;
    load_data  = d;
    load_pair  = p;
    tick();
    load_valid = 1'b0;
    load_data  = 16'($urandom);
    chk("err_cleared_on_load", 16'(err), 16'd0);
    chk("load_ready_shift", 16'(load_ready), 16'd0);

    while (act_cnt < n && cyc < 64) begin
      act = toggle ? (cyc % 2 == 0) : 1'b1;
      chk("data_in", 16'(data_in), (d >> (2*act_cnt)) & 16'h0003);
      chk("operand_valid", 16'(operand_valid), 16'd1);
      chk("result_valid_shift", 16'(result_valid), 16'd0);
      alu_active   = act;
      alu_data_out = feed[2*act_cnt +: 2];
      alu_op_done  = act && (act_cnt + 1 == done_at);
      tick();
      if (act) act_cnt++;
      cyc++;
    end
    alu_active   = 1'b0;
    alu_op_done  = 1'b0;
    alu_data_out = 2'($urandom);
    chk("result_valid_done", 16'(result_valid), 16'd1);
    chk("operand_valid_done", 16'(operand_valid), 16'd0);
    chk("data_in_done", 16'(data_in), 16'd0);
  endtask

  // Hold DONE for 'stall' cycles, compare against the scoreboard, release.
  task automatic finish_op(input int stall);
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int k = 0; k < stall; k++) begin
      chk("result_valid_stall", 16'(result_valid), 16'd1);
      chk("result_data_stall", result_data, e.res);
      chk("load_ready_stall", 16'(load_ready), 16'd0);
      result_ready = 1'b0;
      alu_active   = 1'($urandom);
      alu_op_done  = 1'($urandom);
      tick();
    end
    alu_active  = 1'b0;
    alu_op_done = 1'b0;
    chk("result_valid", 16'(result_valid), 16'd1);
    chk("result_data", result_data, e.res);
    chk("err", 16'(err), 16'(e.err));
    $display("result: data=%h err=%0d expected data=%h err=%0d", result_data, err, e.res, e.err);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("result_valid_idle", 16'(result_valid), 16'd0);
    chk("load_ready_idle_after", 16'(load_ready), 16'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    load_valid   = 1'b0;
    load_data    = 16'h0000;
    load_pair    = 1'b0;
    alu_active   = 1'b0;
    alu_op_done  = 1'b0;
    alu_data_out = 2'b00;
    result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_load_ready", 16'(load_ready), 16'd1);
    chk("rst_operand_valid", 16'(operand_valid), 16'd0);
    chk("rst_result_valid", 16'(result_valid), 16'd0);
    chk("rst_result_data", result_data, 16'h0000);
    chk("rst_data_in", 16'(data_in), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // alu_active in IDLE must be ignored
    alu_active = 1'b1;
    tick();
    alu_active = 1'b0;
    chk("idle_ignores_active", 16'(load_ready), 16'd1);

    // Pair 0xA5C3, all chunks 10, done on 8th cycle
    run_shift(16'hA5C3, 1'b1, 8, 1'b0, 16'hAAAA);
    finish_op(0);

    // Single 0x5A (upper byte junk), all chunks 11
    run_shift(16'hC35A, 1'b0, 4, 1'b0, 16'hFFFF);
    finish_op(0);

    // Pair 0x1234 with alu_active toggling
    run_shift(16'h1234, 1'b1, 8, 1'b1, 16'($urandom));
    finish_op(0);

    // Backpressure, then load in the very first IDLE cycle
    run_shift(16'($urandom), 1'b1, 8, 1'b0, 16'($urandom));
    finish_op(5);

    // Length mismatch: op_done on 3rd active cycle of a pair
    run_shift(16'hBEEF, 1'b1, 3, 1'b0, 16'h9C6D);
    finish_op(0);

    // Next load clears err; single with op_done late (never before last)
    run_shift(16'h007E, 1'b0, 9, 1'b0, 16'h00B4);
    finish_op(1);

    // Single finished early by op_done
    run_shift(16'h00E1, 1'b0, 2, 1'b1, 16'h0007);
    finish_op(0);

    // Async reset on the 5th active cycle of a pair op
    chk("load_ready_pre_rst", 16'(load_ready), 16'd1);
    load_valid = 1'b1;
    load_data  = 16'h1234;
    load_pair  = 1'b1;
    tick();
    load_valid   = 1'b0;
    alu_active   = 1'b1;
    alu_data_out = 2'b01;
    repeat (4) tick();
    chk("operand_valid_pre_rst", 16'(operand_valid), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_load_ready", 16'(load_ready), 16'd1);
    chk("arst_operand_valid", 16'(operand_valid), 16'd0);
    chk("arst_result_valid", 16'(result_valid), 16'd0);
    chk("arst_err", 16'(err), 16'd0);
    chk("arst_data_in", 16'(data_in), 16'd0);
    chk("arst_result_data", result_data, 16'h0000);
    alu_active = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_result_valid", 16'(result_valid), 16'd0);

    run_shift(16'h0096, 1'b0, 4, 1'b0, 16'h0039);
    finish_op(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
